// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Consumed by pipeline_ctrl and hazard_detect.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        MEM_WAIT
    } state_t;

    localparam logic [1:0] LOAD_USE_BUBBLES = 2'd1;
    localparam logic [1:0] MEM_RAW_BUBBLES  = 2'd1;
    localparam logic [4:0] REG_ZERO         = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard matcher: hit flags and required bubble count.
// Build option: PIPE_FORWARDING_EN limits hazards to load-use on EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int ALU_RAW_BUBBLES = 2
) (
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       idUsesRt,
    input  logic       exRegWrite,
    input  logic       exMemRead,
    input  logic [4:0] exDest,
    input  logic       memRegWrite,
    input  logic [4:0] memDest,
    output logic       exHit,
    output logic       memHit,
    output logic       hazard,
    output logic [1:0] bubbles
);

    logic ex_rs, ex_rt, mem_rs, mem_rt;

    assign ex_rs  = exRegWrite && idRs == exDest && idRs != REG_ZERO;
    assign ex_rt  = exRegWrite && idUsesRt
                  && idRt == exDest && idRt != REG_ZERO;
    assign mem_rs = memRegWrite && idRs == memDest && idRs != REG_ZERO;
    assign mem_rt = memRegWrite && idUsesRt
                  && idRt == memDest && idRt != REG_ZERO;

    assign exHit  = ex_rs || ex_rt;
    assign memHit = mem_rs || mem_rt;

`ifdef PIPE_FORWARDING_EN
    // Forwarding covers ALU results; only a load in EX is too late.
    always_comb begin
        hazard  = exMemRead && exHit;
        bubbles = hazard ? LOAD_USE_BUBBLES : 2'd0;
    end
`else
    localparam logic [1:0] ALU_B = 2'(ALU_RAW_BUBBLES);

    logic unused_load;
    assign unused_load = exMemRead;

    // WB needs no check: the register file writes before it reads.
    always_comb begin
        hazard  = 1'b0;
        bubbles = 2'd0;
        if (exHit) begin
            hazard  = 1'b1;
            bubbles = ALU_B;
        end else if (memHit) begin
            hazard  = 1'b1;
            bubbles = MEM_RAW_BUBBLES;
        end
    end
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer driving the PC and pipeline register enables.
// Build option: PIPE_FORWARDING_EN (load-use-only hazards).
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int ALU_RAW_BUBBLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exRegWrite,
    input  logic             exMemRead,
    input  logic [4:0]       exDest,
    input  logic             memRegWrite,
    input  logic [4:0]       memDest,
    input  logic             redirect,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             exMemWrite,
    output logic             memWbWrite,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             exMemFlush,
    output logic [CNT_W-1:0] stallCount
);

    state_t     state, state_nx;
    logic [1:0] bcnt, bcnt_nx;
    logic       hazard;
    logic [1:0] need;
    logic [1:0] unused_hits;
    logic       freeze;
    logic       bubble;

    hazard_detect #(
        .ALU_RAW_BUBBLES(ALU_RAW_BUBBLES)
    ) u_hazard (
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRt   (idUsesRt),
        .exRegWrite (exRegWrite),
        .exMemRead  (exMemRead),
        .exDest     (exDest),
        .memRegWrite(memRegWrite),
        .memDest    (memDest),
        .exHit      (unused_hits[0]),
        .memHit     (unused_hits[1]),
        .hazard     (hazard),
        .bubbles    (need)
    );

    assign freeze = memReq && !memReady;
    assign bubble = !freeze && !redirect
                 && (state == STALL || hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            bcnt       <= 2'd0;
            stallCount <= '0;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
            if ((bubble || freeze) && stallCount != {CNT_W{1'b1}})
                stallCount <= stallCount + CNT_W'(1);
        end
    end

    // bcnt holds bubbles still owed after the current one.
    always_comb begin
        state_nx = RUN;
        bcnt_nx  = bcnt;
        if (freeze) begin
            state_nx = MEM_WAIT;
            bcnt_nx  = 2'd0;
        end else if (redirect) begin
            state_nx = RUN;
            bcnt_nx  = 2'd0;
        end else if (state == STALL) begin
            bcnt_nx  = bcnt - 2'd1;
            state_nx = (bcnt > 2'd1) ? STALL : RUN;
        end else if (hazard) begin
            bcnt_nx  = need - 2'd1;
            state_nx = (need > 2'd1) ? STALL : RUN;
        end
    end

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        exMemWrite = 1'b1;
        memWbWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        exMemFlush = 1'b0;
        if (reset) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbWrite = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
        end else if (freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbWrite = 1'b0;
        end else if (redirect) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
        end else if (bubble) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl with a bubble-debt reference model.
// Honours PIPE_FORWARDING_EN when compiled with it.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 8;
    localparam int ALU_B   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       idRs, idRt, exDest, memDest;
    logic             idUsesRt, exRegWrite, exMemRead, memRegWrite;
    logic             redirect, memReq, memReady;
    logic             pcWrite, ifIdWrite, exMemWrite, memWbWrite;
    logic             ifIdFlush, idExFlush, exMemFlush;
    logic [CNT_W-1:0] stallCount;

    int checks = 0;
    int errors = 0;

    int pend    = 0;
    int cnt     = 0;
    bit started = 1'b0;

    pipeline_ctrl #(
        .CNT_W(CNT_W),
        .ALU_RAW_BUBBLES(ALU_B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRt   (idUsesRt),
        .exRegWrite (exRegWrite),
        .exMemRead  (exMemRead),
        .exDest     (exDest),
        .memRegWrite(memRegWrite),
        .memDest    (memDest),
        .redirect   (redirect),
        .memReq     (memReq),
        .memReady   (memReady),
        .pcWrite    (pcWrite),
        .ifIdWrite  (ifIdWrite),
        .exMemWrite (exMemWrite),
        .memWbWrite (memWbWrite),
        .ifIdFlush  (ifIdFlush),
        .idExFlush  (idExFlush),
        .exMemFlush (exMemFlush),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    // Bubbles the instruction in ID needs, straight from the hit rules.
    function automatic int need_bubbles();
        bit ex_hit, mem_hit;
        ex_hit  = exRegWrite && ((idRs != 0 && idRs == exDest)
               || (idUsesRt && idRt != 0 && idRt == exDest));
        mem_hit = memRegWrite && ((idRs != 0 && idRs == memDest)
               || (idUsesRt && idRt != 0 && idRt == memDest));
`ifdef PIPE_FORWARDING_EN
        return (exMemRead && ex_hit) ? 1 : 0;
`else
        if (ex_hit) return ALU_B;
        if (mem_hit) return 1;
        return 0;
`endif
    endfunction

    // {pcWrite, ifIdWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush, exMemFlush}
    function automatic logic [6:0] model_out();
        if (reset) return 7'b0000111;
        if (memReq && !memReady) return 7'b0000000;
        if (redirect) return 7'b1111111;
        if (pend > 0 || need_bubbles() > 0) return 7'b0011010;
        return 7'b1111000;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (reset) begin
            pend <= 0;
            cnt  <= 0;
        end else if (memReq && !memReady) begin
            pend <= 0;
            cnt  <= sat_inc(cnt);
        end else if (redirect) begin
            pend <= 0;
        end else if (pend > 0) begin
            pend <= pend - 1;
            cnt  <= sat_inc(cnt);
        end else if (need_bubbles() > 0) begin
            pend <= need_bubbles() - 1;
            cnt  <= sat_inc(cnt);
        end
    end

    always @(negedge clk) begin
        logic [6:0] got, exp;
        #2;
        if (started) begin
            got = {pcWrite, ifIdWrite, exMemWrite, memWbWrite,
                   ifIdFlush, idExFlush, exMemFlush};
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model_outs t=%0t got=%b exp=%b", $time, got, exp);
            end
            checks++;
            if (stallCount !== CNT_W'(cnt)) begin
                errors++;
                $display("FAIL model_count t=%0t got=%0d exp=%0d",
                         $time, stallCount, cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic idle();
        reset       = 1'b0;
        idRs        = 5'd0;
        idRt        = 5'd0;
        idUsesRt    = 1'b0;
        exRegWrite  = 1'b0;
        exMemRead   = 1'b0;
        exDest      = 5'd0;
        memRegWrite = 1'b0;
        memDest     = 5'd0;
        redirect    = 1'b0;
        memReq      = 1'b0;
        memReady    = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

`ifdef PIPE_FORWARDING_EN
    localparam int RAW_CNT = 1;
`else
    localparam int RAW_CNT = 2;
`endif

    initial begin
        idle();
        reset = 1'b1;
        next(); #3;
        chk("rst_pc", 32'(pcWrite), 0);
        chk("rst_wb", 32'(memWbWrite), 0);
        chk("rst_flush", 32'({ifIdFlush, idExFlush, exMemFlush}), 7);

        next(); idle(); #3;
        chk("post_rst_cnt", 32'(stallCount), 0);
        chk("post_rst_pc", 32'(pcWrite), 1);

        // Load into $2 in EX, ID reads rs=2.
        next();
        exRegWrite = 1'b1; exMemRead = 1'b1; exDest = 5'd2; idRs = 5'd2;
        #3;
        chk("raw_b1_pc", 32'(pcWrite), 0);
        chk("raw_b1_idex", 32'(idExFlush), 1);
`ifndef PIPE_FORWARDING_EN
        next(); #3;
        chk("raw_b2_pc", 32'(pcWrite), 0);
`endif
        next(); idle(); #3;
        chk("raw_done_pc", 32'(pcWrite), 1);
        chk("raw_cnt", 32'(stallCount), RAW_CNT);

        for (int i = 0; i < 3; i++) begin
            next(); memReq = 1'b1; memReady = 1'b0; #3;
            chk("mw_en", 32'({pcWrite, ifIdWrite, exMemWrite, memWbWrite}), 0);
        end
        next(); memReady = 1'b1; #3;
        chk("mw_ready_en", 32'({pcWrite, ifIdWrite, exMemWrite, memWbWrite}), 15);
        next(); idle(); #3;
        chk("mw_cnt", 32'(stallCount), RAW_CNT + 3);

        // Redirect arriving on the cycle after the first bubble.
        next();
        exRegWrite = 1'b1; exMemRead = 1'b1; exDest = 5'd3; idRs = 5'd3;
        #3;
        chk("st_b1_pc", 32'(pcWrite), 0);
        next(); idle(); redirect = 1'b1; #3;
        chk("st_redir_fl", 32'({ifIdFlush, idExFlush, exMemFlush}), 7);
        chk("st_redir_pc", 32'(pcWrite), 1);
        next(); idle(); #3;
        chk("st_after_pc", 32'(pcWrite), 1);
        chk("st_after_idex", 32'(idExFlush), 0);
        chk("st_cnt", 32'(stallCount), RAW_CNT + 4);

        for (int i = 0; i < 2; i++) begin
            next(); memReq = 1'b1; memReady = 1'b0; redirect = 1'b1; #3;
            chk("frz_redir_fl", 32'(ifIdFlush), 0);
            chk("frz_redir_pc", 32'(pcWrite), 0);
        end
        next(); memReady = 1'b1; #3;
        chk("frz_rel_fl", 32'({ifIdFlush, idExFlush, exMemFlush}), 7);
        chk("frz_rel_pc", 32'(pcWrite), 1);
        next(); idle(); #3;
        chk("frz_cnt", 32'(stallCount), RAW_CNT + 6);

        next();
        exRegWrite = 1'b1; exMemRead = 1'b1; exDest = 5'd0;
        idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b1;
        #3;
        chk("r0_pc", 32'(pcWrite), 1);

        next(); idle(); memReq = 1'b1; #3;
        chk("rstmw_frz", 32'(pcWrite), 0);
        next(); reset = 1'b1; #3;
        chk("rstmw_fl", 32'(ifIdFlush), 1);
        next(); idle(); #3;
        chk("rstmw_pc", 32'(pcWrite), 1);
        chk("rstmw_cnt", 32'(stallCount), 0);

        for (int i = 0; i < CNT_MAX + 5; i++) begin
            next(); idle(); memReq = 1'b1;
        end
        next(); idle(); #3;
        chk("sat_cnt", 32'(stallCount), CNT_MAX);

        for (int i = 0; i < 3000; i++) begin
            next();
            reset       = ($urandom_range(299) == 0);
            idRs        = 5'($urandom_range(3));
            idRt        = 5'($urandom_range(3));
            idUsesRt    = 1'($urandom);
            exRegWrite  = 1'($urandom);
            exMemRead   = 1'($urandom);
            exDest      = 5'($urandom_range(3));
            memRegWrite = 1'($urandom);
            memDest     = 5'($urandom_range(3));
            redirect    = ($urandom_range(9) == 0);
            memReq      = ($urandom_range(4) == 0);
            memReady    = 1'($urandom);
        end

        next(); idle();
        next(); next();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write-enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It sequences three events: register RAW hazards, taken control transfers resolved in MEM, and multi-cycle data-memory accesses. It also keeps a saturating bubble counter for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of stall counter
- ALU_RAW_BUBBLES, 2, bubbles for an ALU RAW on the EX-stage producer when forwarding is compiled out

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous reset; active-high, sampled on posedge clk
- idRs  in  5  rs field of the instruction in ID
- idRt  in  5  rt field of the instruction in ID
- idUsesRt  in  1  ID instruction reads rt
- exRegWrite, exMemRead  in  1 each  ID_EX control outputs
- exDest  in  5  destination register of the instruction in EX
- memRegWrite  in  1  EX_MEM regWrite
- memDest  in  5  EX_MEM dataForWR
- redirect  in  1  branch (EQ/NE taken), jump, JR or JAL resolved in MEM
- memReq  in  1  EX_MEM memRead or memWrite
- memReady  in  1  data memory completes the access this cycle
- pcWrite, ifIdWrite, exMemWrite, memWbWrite  out  1 each  register load enables
- ifIdFlush, idExFlush, exMemFlush  out  1 each  load a bubble (all-zero) this cycle
- stallCount  out  CNT_W  bubble cycles since reset

## Operation
- States: RUN, STALL, MEM_WAIT. The state register and a 2-bit bubble counter `bcnt` are clocked. Outputs are combinational from state and inputs.
- Matches: rsHit(X) = idRs==XDest && XRegWrite && idRs!=0. rtHit is the same with idRt, gated by idUsesRt.
- Priority, highest first:
  1. memReq && !memReady → MEM_WAIT.
  2. redirect.
  3. Hazard.
  4. Normal.
- MEM_WAIT:
  - All write enables are 0 and all flushes are 0, so the whole pipe freezes.
  - memReady → RUN. The redirect present in that cycle is honoured that same cycle.
- Redirect, any state other than a freezing MEM_WAIT:
  - ifIdFlush=idExFlush=exMemFlush=1.
  - pcWrite=1, memWbWrite=1.
  - bcnt cleared, next state RUN.
- Hazard in RUN:
  - pcWrite=0, ifIdWrite=0, idExFlush=1, exMemWrite=memWbWrite=1.
  - Next state STALL with `bcnt` = remaining bubbles − 1. If that value is 0, next state is RUN.
- STALL: same outputs as a hazard. Decrement `bcnt`, then return to RUN when it is 0.
- Normal: all write enables 1, all flushes 0.
- stallCount increments on every cycle with a hazard bubble or MEM_WAIT freeze. It saturates at all-ones.

## Timing
- Reset cycle and its outputs:
  - State becomes RUN, bcnt=0, stallCount=0.
  - While reset is high: pcWrite=ifIdWrite=exMemWrite=memWbWrite=0, all flushes=1.
- Stall decisions take effect in the same cycle the hazard is visible; there is no registered latency on enables.
- A load-use hazard with forwarding inserts exactly 1 bubble. The dependent instruction enters EX on cycle N+2 relative to the load entering EX on N.
- Redirect flush takes one cycle with no extra penalty beyond the 3 flushed slots.
- Simultaneous hazard and redirect: redirect wins and no bubble is counted.
- Reset mid-STALL or mid-MEM_WAIT aborts immediately.

## Configuration
- PIPE_FORWARDING_EN defined:
  - EX/MEM forwarding exists. Only load-use is a hazard: exMemRead && (rsHit(ex)||rtHit(ex)), giving 1 bubble.
  - MEM-stage matches are ignored.
- PIPE_FORWARDING_EN undefined:
  - Any rsHit/rtHit on EX gives ALU_RAW_BUBBLES bubbles.
  - Otherwise, a hit on MEM gives 1 bubble.
  - The register file writes before it reads within a cycle, so WB needs no stall.

## Structure
- Package pipe_ctrl_pkg holds:
  - The state enum (RUN, STALL, MEM_WAIT).
  - The constants LOAD_USE_BUBBLES=1 and MEM_RAW_BUBBLES=1.
  - The register-zero constant.
- One sub-module, hazard_detect, is purely combinational. It produces the hit flags and the required bubble count. It is instantiated once.

## Test plan
- lw $2 in EX (exMemRead=1, exDest=2), ID reads rs=2, forwarding on → one cycle with pcWrite=0 and idExFlush=1, then RUN; stallCount=1.
- Same lw, forwarding off, add with exDest=2 → 2 consecutive bubbles, then RUN; stallCount=2.
- memReq=1 with memReady=0 for 3 cycles → all enables 0 for 3 cycles; on the memReady cycle all enables are 1; stallCount=3.
- redirect=1 during STALL with bcnt=1 → the three flushes are 1, pcWrite=1, next state RUN, no further bubble.
- redirect=1 while frozen (memReq=1, memReady=0) → no flush until memReady=1, then flushes in that cycle.
- idRs=0 with exDest=0 and exRegWrite=1 → no stall; reset asserted mid-MEM_WAIT → next cycle RUN, stallCount=0.
